// File: rtl/viterbi_out_select.sv
// Output-decision unit for the Viterbi decoder: picks either the externally selected
// state or the minimum-metric state through a pipelined binary comparison tree.
module viterbi_out_select #(
    parameter int NSTATES = 4,
    parameter int MW      = 3,
    parameter int DW      = 3,
    parameter int MODULAR = 0,
    localparam int SW     = ($clog2(NSTATES) < 1) ? 1 : $clog2(NSTATES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [NSTATES*MW-1:0] metrics,
    input  logic [NSTATES*DW-1:0] data,
    input  logic                  mode,
    input  logic [SW-1:0]         sel,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic [SW-1:0]         out_idx,
    output logic [MW-1:0]         out_metric,
    output logic                  out_tie
);

    typedef struct packed {
        logic [SW-1:0] idx;
        logic [MW-1:0] met;
        logic [DW-1:0] dat;
        logic          tie;
    } cand_t;

    // Stage 0 is the input register; stage l (1..SW-1) holds tree level l.
    cand_t                  lvl_r   [SW][NSTATES];
    cand_t                  nxt_s   [SW][NSTATES];
    logic                   v_r     [SW];
    logic                   mode_r  [SW];
    logic [SW-1:0]          sel_r   [SW];
    logic [NSTATES*MW-1:0]  allm_r  [SW];
    cand_t                  fin_s;
    logic                   eq_any_s;

    // a < b, either plain unsigned or modulo-2^MW (sign of the MW-bit difference)
    function automatic logic lt(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] diff;
        diff = a - b;
        if (MODULAR != 0) begin
            lt = diff[MW-1];
        end else begin
            lt = (a < b);
        end
    endfunction

    // One tree node; on equal metrics the even (lower-index) candidate wins.
    function automatic cand_t node(input cand_t a, input cand_t b,
                                   input logic auto_m, input logic sbit);
        cand_t w;
        logic  pick_b;
        if (auto_m) begin
            pick_b = lt(b.met, a.met);
        end else begin
            pick_b = sbit;
        end
        if (pick_b) begin
            w = b;
        end else begin
            w = a;
        end
        w.tie = auto_m & (w.tie | (a.met == b.met));
        return w;
    endfunction

    // Candidate sets entering each pipeline stage
    always_comb begin
        for (int l = 0; l < SW; l++) begin
            for (int j = 0; j < NSTATES; j++) begin
                nxt_s[l][j] = '0;
            end
        end
        for (int k = 0; k < NSTATES; k++) begin
            nxt_s[0][k].idx = SW'(k);
            nxt_s[0][k].met = metrics[k*MW +: MW];
            nxt_s[0][k].dat = data[k*DW +: DW];
            nxt_s[0][k].tie = 1'b0;
        end
        for (int l = 1; l < SW; l++) begin
            for (int j = 0; j < NSTATES / 2; j++) begin
                nxt_s[l][j] = node(lvl_r[l-1][2*j], lvl_r[l-1][2*j+1],
                                   mode_r[l-1], sel_r[l-1][l-1]);
            end
        end
    end

    // Final tree level plus the "another state equals the winner" check,
    // which covers non-transitive modular compares the path alone can miss.
    always_comb begin
        fin_s    = node(lvl_r[SW-1][0], lvl_r[SW-1][1], mode_r[SW-1], sel_r[SW-1][SW-1]);
        eq_any_s = 1'b0;
        for (int k = 0; k < NSTATES; k++) begin
            eq_any_s = eq_any_s | ((allm_r[SW-1][k*MW +: MW] == fin_s.met) &&
                                   (SW'(k) != fin_s.idx));
        end
    end

    // Input register and intermediate tree levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < SW; l++) begin
                v_r[l]    <= 1'b0;
                mode_r[l] <= 1'b0;
                sel_r[l]  <= '0;
                allm_r[l] <= '0;
                for (int j = 0; j < NSTATES; j++) begin
                    lvl_r[l][j] <= '0;
                end
            end
        end else begin
            v_r[0] <= in_valid;
            if (in_valid) begin
                mode_r[0] <= mode;
                sel_r[0]  <= sel;
                allm_r[0] <= metrics;
                for (int k = 0; k < NSTATES; k++) begin
                    lvl_r[0][k] <= nxt_s[0][k];
                end
            end
            for (int l = 1; l < SW; l++) begin
                v_r[l]    <= v_r[l-1];
                mode_r[l] <= mode_r[l-1];
                sel_r[l]  <= sel_r[l-1];
                allm_r[l] <= allm_r[l-1];
                for (int j = 0; j < NSTATES; j++) begin
                    lvl_r[l][j] <= nxt_s[l][j];
                end
            end
        end
    end

    // Output registers; payload holds while no valid result arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_metric <= '0;
            out_tie    <= 1'b0;
        end else begin
            out_valid <= v_r[SW-1];
            if (v_r[SW-1]) begin
                out_data   <= fin_s.dat;
                out_idx    <= fin_s.idx;
                out_metric <= fin_s.met;
                out_tie    <= mode_r[SW-1] & (fin_s.tie | eq_any_s);
            end
        end
    end

endmodule

// File: tb/tb_viterbi_out_select.sv
// Scoreboard bench for viterbi_out_select: three builds (default, modular, 8-state)
// checked against a tournament reference model with latency and hold checks.
module tb_viterbi_out_select;

    typedef struct {
        int data;
        int idx;
        int metric;
        int tie;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        va = 1'b0, mode_a = 1'b0;
    logic [1:0]  sel_a = 2'd0;
    logic [11:0] met_a = 12'd0, dat_a = 12'd0;
    logic        vw = 1'b0, mode_w = 1'b0;
    logic [2:0]  sel_w = 3'd0;
    logic [39:0] met_w = 40'd0;
    logic [15:0] dat_w = 16'd0;

    logic        oa_valid, oa_tie, om_valid, om_tie, ow_valid, ow_tie;
    logic [2:0]  oa_data, oa_metric, om_data, om_metric;
    logic [1:0]  oa_idx, om_idx, ow_data;
    logic [2:0]  ow_idx;
    logic [4:0]  ow_metric;

    exp_t sbq[3][$];
    exp_t last[3];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    viterbi_out_select #(.NSTATES(4), .MW(3), .DW(3), .MODULAR(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(va), .metrics(met_a), .data(dat_a),
        .mode(mode_a), .sel(sel_a), .out_valid(oa_valid), .out_data(oa_data),
        .out_idx(oa_idx), .out_metric(oa_metric), .out_tie(oa_tie));

    viterbi_out_select #(.NSTATES(4), .MW(3), .DW(3), .MODULAR(1)) u_m (
        .clk(clk), .rst(rst), .in_valid(va), .metrics(met_a), .data(dat_a),
        .mode(mode_a), .sel(sel_a), .out_valid(om_valid), .out_data(om_data),
        .out_idx(om_idx), .out_metric(om_metric), .out_tie(om_tie));

    viterbi_out_select #(.NSTATES(8), .MW(5), .DW(2), .MODULAR(0)) u_w (
        .clk(clk), .rst(rst), .in_valid(vw), .metrics(met_w), .data(dat_w),
        .mode(mode_w), .sel(sel_w), .out_valid(ow_valid), .out_data(ow_data),
        .out_idx(ow_idx), .out_metric(ow_metric), .out_tie(ow_tie));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit less(input int a, input int b, input int mw, input int modular);
        int mask;
        mask = (1 << mw) - 1;
        if (modular != 0) return ((((a - b) & mask) >> (mw - 1)) & 1) == 1;
        return a < b;
    endfunction

    // Reference: knockout tournament over pairs, or direct pick by sel
    function automatic exp_t model(input int ns, input int mw, input int modular,
                                   input int m[8], input int d[8],
                                   input int mode, input int sel);
        exp_t e;
        int c[8];
        int n, w;
        e.tie = 0;
        e.cyc = 0;
        if (mode != 0) begin
            for (int i = 0; i < 8; i++) c[i] = i;
            n = ns;
            while (n > 1) begin
                for (int j = 0; j < n / 2; j++)
                    c[j] = less(m[c[2*j+1]], m[c[2*j]], mw, modular) ? c[2*j+1] : c[2*j];
                n = n / 2;
            end
            w = c[0];
            for (int i = 0; i < ns; i++)
                if (i != w && m[i] == m[w]) e.tie = 1;
        end else begin
            w = sel;
        end
        e.idx = w;
        e.metric = m[w];
        e.data = d[w];
        return e;
    endfunction

    task automatic push(input int k, input int ns, input int mw, input int modular,
                        input int lat, input int m[8], input int d[8],
                        input int mode, input int sel);
        exp_t e;
        e = model(ns, mw, modular, m, d, mode, sel);
        e.cyc = cyc + lat;
        sbq[k].push_back(e);
    endtask

    task automatic drive_a(input bit v, input int m[8], input int d[8],
                           input int md, input int s);
        @(posedge clk);
        #1;
        va = v;
        vw = 1'b0;
        mode_a = (md != 0);
        sel_a = 2'(s);
        for (int k = 0; k < 4; k++) begin
            met_a[k*3 +: 3] = 3'(m[k]);
            dat_a[k*3 +: 3] = 3'(d[k]);
        end
        if (v) begin
            push(0, 4, 3, 0, 3, m, d, md, s);
            push(1, 4, 3, 1, 3, m, d, md, s);
        end
    endtask

    task automatic drive_w(input bit v, input int m[8], input int d[8],
                           input int md, input int s);
        @(posedge clk);
        #1;
        vw = v;
        va = 1'b0;
        mode_w = (md != 0);
        sel_w = 3'(s);
        for (int k = 0; k < 8; k++) begin
            met_w[k*5 +: 5] = 5'(m[k]);
            dat_w[k*2 +: 2] = 2'(d[k]);
        end
        if (v) push(2, 8, 5, 0, 4, m, d, md, s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            va = 1'b0;
            vw = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        va = 1'b0;
        vw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sbq[k].delete();
            last[k] = '{0, 0, 0, 0, 0};
        end
        #1;
        compared++;
        if ({oa_valid, oa_data, oa_idx, oa_metric, oa_tie, om_valid, om_data, om_idx,
             om_metric, om_tie, ow_valid, ow_data, ow_idx, ow_metric, ow_tie} != '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got a=%b/%0d/%0d/%0d/%b w=%b/%0d/%0d/%0d/%b, required all 0",
                     oa_valid, oa_data, oa_idx, oa_metric, oa_tie,
                     ow_valid, ow_data, ow_idx, ow_metric, ow_tie);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check(input int k, input logic v, input int d, input int i,
                         input int m, input int t);
        exp_t e;
        compared++;
        if (v) begin
            if (sbq[k].size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_valid dut%0d: got data=%0d idx=%0d metric=%0d, required no output",
                         k, d, i, m);
                last[k] = '{d, i, m, t, 0};
            end else begin
                e = sbq[k].pop_front();
                if (d != e.data || i != e.idx || m != e.metric || t != e.tie || cyc != e.cyc) begin
                    mismatched++;
                    $display("FAIL result dut%0d: got data=%0d idx=%0d metric=%0d tie=%0d cyc=%0d, required data=%0d idx=%0d metric=%0d tie=%0d cyc=%0d",
                             k, d, i, m, t, cyc, e.data, e.idx, e.metric, e.tie, e.cyc);
                end
                last[k] = e;
            end
        end else if (d != last[k].data || i != last[k].idx || m != last[k].metric || t != last[k].tie) begin
            mismatched++;
            $display("FAIL hold dut%0d: got data=%0d idx=%0d metric=%0d tie=%0d, required data=%0d idx=%0d metric=%0d tie=%0d",
                     k, d, i, m, t, last[k].data, last[k].idx, last[k].metric, last[k].tie);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check(0, oa_valid, int'(oa_data), int'(oa_idx), int'(oa_metric), int'(oa_tie));
            check(1, om_valid, int'(om_data), int'(om_idx), int'(om_metric), int'(om_tie));
            check(2, ow_valid, int'(ow_data), int'(ow_idx), int'(ow_metric), int'(ow_tie));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m[8];
        int d[8];
        int rmax;
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) last[k] = '{0, 0, 0, 0, 0};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Two samples in flight, then reset: they must never emerge
        m = '{2, 7, 1, 5, 0, 0, 0, 0};
        d = '{1, 4, 3, 6, 0, 0, 0, 0};
        drive_a(1'b1, m, d, 1, 0);
        drive_a(1'b1, m, d, 0, 3);
        do_reset();
        idle(5);

        // External select of state 2
        drive_a(1'b1, m, d, 0, 2);
        // Auto with tie at metric 2, then tie broken by raising s0
        m = '{2, 6, 2, 4, 0, 0, 0, 0};
        d = '{1, 0, 5, 7, 0, 0, 0, 0};
        drive_a(1'b1, m, d, 1, 0);
        m[0] = 3;
        drive_a(1'b1, m, d, 1, 0);
        // Wrap-around metrics: modular and unsigned builds disagree
        m = '{5, 6, 7, 1, 0, 0, 0, 0};
        drive_a(1'b1, m, d, 1, 0);
        idle(4);

        // Streaming with alternating mode and a bubble after the third sample
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 8; k++) begin
                m[k] = $urandom_range(0, 7);
                d[k] = $urandom_range(0, 7);
            end
            drive_a(s != 3, m, d, s % 2, $urandom_range(0, 3));
        end
        idle(4);

        // Eight-state build: minimum at state 7, then all equal
        for (int k = 0; k < 8; k++) begin
            m[k] = $urandom_range(1, 31);
            d[k] = $urandom_range(0, 3);
        end
        m[7] = 0;
        drive_w(1'b1, m, d, 1, 0);
        for (int k = 0; k < 8; k++) m[k] = 9;
        drive_w(1'b1, m, d, 1, 5);
        drive_w(1'b1, m, d, 0, 6);
        idle(5);

        // Randomised mix of builds, modes, bubbles and narrow metric ranges
        for (int it = 0; it < 300; it++) begin
            if (it == 150) do_reset();
            rmax = ($urandom_range(0, 1) == 0) ? 2 : 7;
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < 8; k++) begin
                    m[k] = (rmax == 2) ? $urandom_range(0, 2) : $urandom_range(0, 31);
                    d[k] = $urandom_range(0, 3);
                end
                drive_w($urandom_range(0, 3) != 0, m, d, $urandom_range(0, 1), $urandom_range(0, 7));
            end else begin
                for (int k = 0; k < 8; k++) begin
                    m[k] = $urandom_range(0, rmax);
                    d[k] = $urandom_range(0, 7);
                end
                drive_a($urandom_range(0, 3) != 0, m, d, $urandom_range(0, 1), $urandom_range(0, 3));
            end
        end

        // Drain with a bounded wait
        for (int w = 0; w < 20; w++) begin
            if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0) break;
            idle(1);
        end
        idle(2);
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (sbq[k].size() != 0) begin
                mismatched++;
                $display("FAIL drain dut%0d: got %0d results outstanding, required 0", k, sbq[k].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/viterbi_out_select.md
Name: viterbi_out_select

Overview:
- Parametrised, pipelined output-decision unit for the Viterbi decoder. Each valid cycle it takes one path metric and one survivor/decoded word per trellis state.
- It emits the word of either the externally selected state or the minimum-metric state, together with that state's index and metric.
- It sits between the ACS/path-metric bank and traceback/output logic. It generalises the fixed 4:1, 3-bit combinational selector to N states, adds automatic best-state search and adds a fixed-latency valid pipeline.

Parameters:
- NSTATES, 4, number of trellis states; power of two, 2..64.
- MW, 3, path-metric width in bits.
- DW, 3, survivor/data word width in bits.
- MODULAR, 0, 0 = unsigned metric compare; 1 = modulo-2^MW compare (a is smaller than b iff bit MW-1 of (a-b) mod 2^MW is 1).
- SW, derived = max(1, clog2(NSTATES)), state-index width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  metrics/data/mode/sel valid this cycle.
- metrics  in  NSTATES*MW  flat metric vector; state k at bits [k*MW +: MW].
- data  in  NSTATES*DW  flat data vector; state k at bits [k*DW +: DW].
- mode  in  1  0 = external select, 1 = auto minimum-metric select.
- sel  in  SW  state index used when mode=0.
- out_valid  out  1  out_* carry a result this cycle.
- out_data  out  DW  data word of the chosen state.
- out_idx  out  SW  index of the chosen state.
- out_metric  out  MW  metric of the chosen state.
- out_tie  out  1  auto mode only: another state had a metric equal to the winner's.

Behaviour:
- Reset, asynchronous on rst rising:
  - all pipeline registers and valid bits clear.
  - out_valid=0, out_data=0, out_idx=0, out_metric=0, out_tie=0.
  - reset mid-operation discards all in-flight samples; no out_valid pulse appears for them.
- Pipeline structure:
  - stage 0 registers inputs on in_valid=1; mode and sel are captured with the sample and travel with it.
  - stages 1..SW are one binary comparison-tree level each, pairing adjacent candidates (2j, 2j+1).
  - output registers are the last tree level.
- Latency: exactly SW+1 cycles from in_valid sampled high to out_valid high; identical in both modes.
- Throughput: one sample per cycle. No back-pressure; the downstream block always accepts.
- in_valid=0 inserts a bubble. Bubble registers may hold stale data, but out_valid must be 0 for them.
- out_data, out_idx, out_metric and out_tie hold their last valid values while out_valid=0.
- Auto mode (mode=1):
  - at each tree node the candidate with the smaller metric wins.
  - on equal metrics the lower index wins.
  - out_tie = OR of equality at every node on the winner's path and of any equality with the winner's final metric at any level (the "some other state tied with the final minimum" condition).
  - MODULAR=1 uses the modulo compare at every node; the result is not required to be transitive across wrap for metric spreads of 2^(MW-1) or more.
- External mode (mode=0):
  - at each level the winner is the candidate whose index bits match sel at that level.
  - output equals state sel's data and metric; out_idx=sel; out_tie=0.
- Widths: no arithmetic widening. The MODULAR subtraction is computed in MW bits; only its MSB is used.
- NSTATES=2 gives SW=1 and latency 2.
- Back-to-back samples with differing mode/sel must not interfere; each result uses its own captured mode/sel.

Test Plan:
- Reset mid-flight, defaults (NSTATES=4, MW=3, DW=3, latency 3): in_valid on 2 consecutive cycles, rst asserted 1 cycle later -> out_valid never rises for those samples; all outputs 0 immediately on rst.
- External mode, same defaults: metrics {s3..s0}={5,1,7,2}, data {6,3,4,1}, mode=0, sel=2 -> 3 cycles later out_valid=1, out_data=3, out_idx=2, out_metric=1, out_tie=0.
- Auto mode: metrics {s3..s0}={4,2,6,2}, data {7,5,0,1}, mode=1 -> out_idx=0, out_data=1, out_metric=2, out_tie=1; same metrics with s0=3 -> out_idx=2, out_data=5, out_tie=0.
- MODULAR=1, auto mode: metrics {s3..s0}={1,7,6,5} -> out_idx=0 (5 precedes 6/7, which precede wrapped 1; s0 wins via tree); unsigned build (MODULAR=0) on same input -> out_idx=3.
- Streaming: 5 consecutive samples alternating mode=0/1 with a 1-cycle bubble after sample 3 -> 5 results in order at cycles 3,4,5,7,8 after the first; outputs hold during the bubble cycle.
- NSTATES=8, MW=5, DW=2: minimum 0 at state 7 -> out_idx=7 after 4 cycles; all metrics equal -> out_idx=0, out_tie=1.
